// File: rtl/cacheline_burst_adaptor_if.sv
// cacheline_burst_adaptor_if: cache-side line request and memory-side burst bus bundle
interface cacheline_burst_adaptor_if #(
  parameter int s_line  = 256,
  parameter int s_burst = 64
);
  logic [s_line-1:0]  line_i;
  logic [s_line-1:0]  line_o;
  logic [31:0]        address_i;
  logic [31:0]        address_o;
  logic               read_i;
  logic               write_i;
  logic               resp_o;
  logic [s_burst-1:0] burst_i;
  logic [s_burst-1:0] burst_o;
  logic               read_o;
  logic               write_o;
  logic               resp_i;
  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );
  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );
endinterface

// File: rtl/cacheline_burst_adaptor.sv
// cacheline_burst_adaptor: runs one 256-bit line fill/writeback as four 64-bit memory beats
module cacheline_burst_adaptor #(
  parameter int s_line  = 256,
  parameter int s_burst = 64
) (
  input logic clk,
  input logic rst,
  cacheline_burst_adaptor_if.slave bus
);
  localparam int num_bursts = s_line / s_burst;
  localparam int cw = $clog2(num_bursts);
  localparam logic [cw-1:0] last = cw'(num_bursts - 1);
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
  state_t state;
  logic [cw-1:0] count;
  logic [s_line-1:0] line_q;
  assign bus.burst_o = bus.write_o ? line_q[count*s_burst +: s_burst] : '0;
  // count wraps back to 0 on the last beat, which is also the entry into DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      count         <= '0;
      line_q        <= '0;
      bus.read_o    <= 1'b0;
      bus.write_o   <= 1'b0;
      bus.resp_o    <= 1'b0;
      bus.line_o    <= '0;
      bus.address_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          count <= '0;
          if (bus.read_i) begin
            state         <= RD;
            bus.read_o    <= 1'b1;
            bus.address_o <= bus.address_i;
          end else if (bus.write_i) begin
            state         <= WR;
            bus.write_o   <= 1'b1;
            bus.address_o <= bus.address_i;
            line_q        <= bus.line_i;
          end
        end
        RD: if (bus.resp_i) begin
          bus.line_o[count*s_burst +: s_burst] <= bus.burst_i;
          count <= count + 1'b1;
          if (count == last) begin
            state      <= DONE;
            bus.read_o <= 1'b0;
            bus.resp_o <= 1'b1;
          end
        end
        WR: if (bus.resp_i) begin
          count <= count + 1'b1;
          if (count == last) begin
            state       <= DONE;
            bus.write_o <= 1'b0;
            bus.resp_o  <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          bus.resp_o <= 1'b0;
        end
      endcase
    end
  end
endmodule
